// File: rtl/etm_mac8.sv
// Multiply-accumulate stage using the 8x8 error-tolerant multiplier (ETM) product rule.
// Sums N_TAPS products per kernel and hands the sum downstream over valid/ready.
module etm_mac8 #(
    parameter int unsigned N_TAPS = 9,
    parameter int unsigned ACC_W  = 24,
    parameter bit          SAT    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy
);

    localparam logic [7:0] NTapsW  = 8'(N_TAPS);
    localparam logic [7:0] LastTap = 8'(N_TAPS - 1);

    typedef enum logic [1:0] {StRun, StDrain, StHold} state_e;

    state_e             state_q, state_d;
    logic [7:0]         tap_q, tap_d;
    logic [15:0]        p_q;
    logic               pv_q;
    logic [ACC_W-1:0]   acc_q, acc_d;

    logic               accept;
    logic               handshake;
    logic [3:0]         ah, al, bh, bl, lo_or;
    logic [7:0]         lo_part, lo_exact, hi_exact;
    logic [15:0]        prod;
    logic [ACC_W:0]     sum_ext;

    assign ah = in_a[7:4];
    assign al = in_a[3:0];
    assign bh = in_b[7:4];
    assign bl = in_b[3:0];
    assign lo_or    = al | bl;
    assign lo_exact = {4'b0, al} * {4'b0, bl};
    assign hi_exact = {4'b0, ah} * {4'b0, bh};

    // Low byte is approximated from the highest set bit of the OR of the low nibbles.
    always_comb begin
        lo_part = 8'h00;
        if (lo_or[3])      lo_part = 8'hFF;
        else if (lo_or[2]) lo_part = 8'h7F;
        else if (lo_or[1]) lo_part = 8'h3F;
        else if (lo_or[0]) lo_part = 8'h1F;
        if (ah == 4'd0 && bh == 4'd0) prod = {8'h00, lo_exact};
        else                          prod = {hi_exact, lo_part};
    end

    assign in_ready  = (state_q == StRun) && (tap_q < NTapsW);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StHold);
    assign handshake = out_valid && out_ready;
    assign out_sum   = acc_q;
    assign busy      = (state_q != StRun) || (tap_q != 8'd0);

    assign sum_ext = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, p_q};

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        acc_d   = acc_q;
        if (pv_q) begin
            // Saturated value stays all-ones: any further add overflows again.
            if (SAT && sum_ext[ACC_W]) acc_d = '1;
            else                       acc_d = sum_ext[ACC_W-1:0];
        end
        unique case (state_q)
            StRun: begin
                if (accept) begin
                    tap_d = tap_q + 8'd1;
                    if (tap_q == LastTap) state_d = StDrain;
                end
            end
            StDrain: begin
                if (pv_q) state_d = StHold;
            end
            StHold: begin
                if (handshake) begin
                    acc_d   = '0;
                    tap_d   = 8'd0;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            tap_q   <= 8'd0;
            p_q     <= 16'd0;
            pv_q    <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            pv_q    <= accept;
            if (accept) p_q <= prod;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_etm_mac8.sv
// Randomized self-checking bench for etm_mac8 against an arithmetic ETM/accumulate model.
// Four instances cover defaults, N_TAPS=1, and 16-bit saturating / wrapping accumulators.
module tb_etm_mac8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  mask = 4'b0000;
    logic [3:0]  iv;
    logic [7:0]  in_a = 8'h00;
    logic [7:0]  in_b = 8'h00;
    logic        out_ready = 1'b0;
    logic [3:0]  rdy, ov, bz;
    logic [23:0] sum0, sum1;
    logic [15:0] sum2, sum3;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign iv = mask & {4{in_valid}};

    etm_mac8 dut0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .in_a(in_a),
                   .in_b(in_b), .out_valid(ov[0]), .out_ready(out_ready), .out_sum(sum0),
                   .busy(bz[0]));
    etm_mac8 #(.N_TAPS(1)) dut1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
                   .in_a(in_a), .in_b(in_b), .out_valid(ov[1]), .out_ready(out_ready),
                   .out_sum(sum1), .busy(bz[1]));
    etm_mac8 #(.ACC_W(16), .SAT(1'b1)) dut2 (.clk(clk), .rst(rst), .in_valid(iv[2]),
                   .in_ready(rdy[2]), .in_a(in_a), .in_b(in_b), .out_valid(ov[2]),
                   .out_ready(out_ready), .out_sum(sum2), .busy(bz[2]));
    etm_mac8 #(.ACC_W(16), .SAT(1'b0)) dut3 (.clk(clk), .rst(rst), .in_valid(iv[3]),
                   .in_ready(rdy[3]), .in_a(in_a), .in_b(in_b), .out_valid(ov[3]),
                   .out_ready(out_ready), .out_sum(sum3), .busy(bz[3]));

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic longint etm(input int a, input int b);
        int lo;
        if (a < 16 && b < 16) return longint'((a % 16) * (b % 16));
        lo = (a % 16) | (b % 16);
        return longint'((a / 16) * (b / 16) * 256 +
               (lo >= 8 ? 255 : lo >= 4 ? 127 : lo >= 2 ? 63 : lo >= 1 ? 31 : 0));
    endfunction

    function automatic longint expect_sum(input int k, input longint total);
        longint maxv;
        maxv = (k >= 2) ? 65535 : 16777215;
        if (k == 3) return total % 65536;
        return (total > maxv) ? maxv : total;
    endfunction

    function automatic longint sum_of(input int k);
        case (k)
            0: return longint'(sum0);
            1: return longint'(sum1);
            2: return longint'(sum2);
            default: return longint'(sum3);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input logic [3:0] m, input string tag, input logic [3:0] vec,
                             input logic e);
        for (int k = 0; k < 4; k++)
            if (m[k]) check($sformatf("%s[%0d]", tag, k), longint'(vec[k]), longint'(e));
    endtask

    // fixed=1 uses fa/fb for every tap; otherwise operands are random.
    task automatic run_kernel(input logic [3:0] m, input int n, input bit gap, input bit fixed,
                              input logic [7:0] fa, input logic [7:0] fb, input bit early,
                              input int hold);
        longint total = 0;
        mask = m;
        out_ready = early;
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                in_valid = 1'b0;
                in_a = 8'($urandom);
                in_b = 8'($urandom);
                tick();
            end
            in_a = fixed ? fa : 8'($urandom);
            in_b = fixed ? fb : 8'($urandom);
            total += etm(int'(in_a), int'(in_b));
            check_all(m, "in_ready_run", rdy, 1'b1);
            check_all(m, "busy_run", bz, (i > 0) ? 1'b1 : 1'b0);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check_all(m, "out_valid_drain", ov, 1'b0);
        check_all(m, "in_ready_drain", rdy, 1'b0);
        check_all(m, "busy_drain", bz, 1'b1);
        tick();
        check_all(m, "out_valid_lat", ov, 1'b1);
        for (int k = 0; k < 4; k++)
            if (m[k]) check($sformatf("out_sum[%0d]", k), sum_of(k), expect_sum(k, total));
        if (hold > 0) begin
            out_ready = 1'b0;
            repeat (hold) tick();
            check_all(m, "out_valid_hold", ov, 1'b1);
            check_all(m, "in_ready_hold", rdy, 1'b0);
            check_all(m, "busy_hold", bz, 1'b1);
            for (int k = 0; k < 4; k++)
                if (m[k]) check($sformatf("out_sum_hold[%0d]", k), sum_of(k),
                                expect_sum(k, total));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_all(m, "out_valid_after", ov, 1'b0);
        check_all(m, "in_ready_after", rdy, 1'b1);
        check_all(m, "busy_after", bz, 1'b0);
        for (int k = 0; k < 4; k++)
            if (m[k]) check($sformatf("acc_clear[%0d]", k), sum_of(k), 0);
    endtask

    logic [7:0] pa [5] = '{8'h0F, 8'h35, 8'h80, 8'hFF, 8'h00};
    logic [7:0] pb [5] = '{8'h0F, 8'h12, 8'h01, 8'hFF, 8'h00};

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_all(4'hF, "rst_in_ready", rdy, 1'b1);
        check_all(4'hF, "rst_out_valid", ov, 1'b0);
        check_all(4'hF, "rst_busy", bz, 1'b0);
        for (int k = 0; k < 4; k++) check($sformatf("rst_sum[%0d]", k), sum_of(k), 0);

        // Single-product directed vectors, then random ones.
        for (int i = 0; i < 5; i++) run_kernel(4'b0010, 1, 1'b0, 1'b1, pa[i], pb[i], 1'b0, 0);
        for (int i = 0; i < 6; i++) run_kernel(4'b0010, 1, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, i % 2);

        run_kernel(4'b0001, 9, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 0);
        run_kernel(4'b0001, 9, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 5);
        run_kernel(4'b0001, 9, 1'b1, 1'b1, 8'h11, 8'h11, 1'b0, 0);
        for (int i = 0; i < 4; i++) run_kernel(4'b0001, 9, i[0], 1'b0, 8'h0, 8'h0, 1'b1, i);

        run_kernel(4'b1100, 9, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 0);
        run_kernel(4'b1100, 9, 1'b0, 1'b1, 8'h0F, 8'h0F, 1'b0, 2);
        for (int i = 0; i < 3; i++) run_kernel(4'b1100, 9, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 1);

        // Abort a kernel after 4 taps; the next kernel must start from zero.
        mask = 4'b0001;
        in_a = 8'hFF;
        in_b = 8'hFF;
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", longint'(ov[0]), 0);
        check("abort_busy", longint'(bz[0]), 0);
        check("abort_sum", sum_of(0), 0);
        tick();
        rst = 1'b0;
        tick();
        check("abort_in_ready", longint'(rdy[0]), 1);
        run_kernel(4'b0001, 9, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
